move_scheduler: RTL and testbench
=================================

# move_scheduler

Turn controller for the Connect-4 board datapath. It arbitrates between the local requester (debounced buttons) and the remote requester (link receiver), so that only the player who owns the turn can steer the column cursor and issue drops. It sequences each drop through a request/acknowledge handshake, then waits for the win/full checks to settle before passing the turn or ending the game. It sits between the input pulse generators and the panel/position update logic, and drives the cursor and turn inputs of the VGA display.

## Interface
- COLS, 7, number of board columns; sets the width of the one-hot cursor and drop column.
- SETTLE_CYCLES, 2, cycles to wait after `drop_done` before sampling `win_a`, `win_b` and `full_panel` (minimum 1).
- TIMEOUT_CYCLES, 50_000_000, idle cycles allowed per turn; used only with MOVE_TIMEOUT_EN.

- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- loc_left / loc_right / loc_put  in  1 each  single-cycle pulses from the local requester
- rem_left / rem_right / rem_put  in  1 each  single-cycle pulses from the remote requester
- local_player  in  1  player id of the local side; static during a game
- new_game  in  1  pulse; restarts play from OVER
- drop_req  out  1  drop request to the board datapath
- drop_col  out  COLS  one-hot target column; valid while `drop_req`=1
- drop_player  out  1  player making the drop; valid while `drop_req`=1
- drop_done  in  1  datapath acknowledge pulse
- drop_invalid  in  1  column full; qualified by `drop_done`
- win_a / win_b / full_panel  in  1 each  board status
- col_sel  out  COLS  one-hot cursor, sent to the display
- turn  out  1  current player (0 = A)
- local_turn  out  1  `turn == local_player`
- invalid_move  out  1  one-cycle pulse
- board_clear  out  1  one-cycle pulse; clears the board datapath
- game_over  out  1  level
- timeout  out  1  one-cycle pulse

## Operation
- **States:** SELECT, DROP, SETTLE, OVER. Reset state is SELECT.
- **Reset values:**
  - `col_sel` = 1 (column 0), `turn` = 0.
  - `drop_req`, `drop_col`, `drop_player` = 0.
  - `invalid_move`, `board_clear`, `game_over`, `timeout` = 0.
  - `local_turn` = !`local_player`.
- **Owner selection:** the owner is the local set of inputs when `local_turn`=1, otherwise the remote set. Pulses from the non-owner are ignored in every state. All requester pulses are ignored outside SELECT.
- **SELECT, owner priority in each cycle:**
  - put wins over moves: latch `drop_col` = `col_sel` and `drop_player` = `turn`, then go to DROP.
  - left and right together: no action.
  - left alone: `col_sel` rotates toward bit 0; bit 0 wraps to bit COLS-1.
  - right alone: `col_sel` rotates toward bit COLS-1; bit COLS-1 wraps to bit 0.
- **DROP:**
  - `drop_req` = 1; `drop_col` and `drop_player` are held stable.
  - Exit when `drop_done` = 1.
  - If `drop_invalid` = 1: pulse `invalid_move`, keep `turn`, return to SELECT.
  - Otherwise: go to SETTLE.
- **SETTLE:**
  - Lasts exactly SETTLE_CYCLES cycles, counted by a counter of width clog2(SETTLE_CYCLES+1).
  - Status is sampled in the last cycle.
  - If `win_a`, `win_b` or `full_panel` is set: go to OVER.
  - Otherwise: toggle `turn` and go to SELECT.
- **OVER:**
  - `game_over` = 1; `turn` and `col_sel` are frozen.
  - `new_game` causes, in the next cycle: `board_clear` pulse, `turn` = 0, `col_sel` = 1, `game_over` = 0, state SELECT.
  - `new_game` outside OVER is ignored.
- **Cursor persistence:** `col_sel` is kept across turns and is never all-zero.

## Timing
- Put accepted in cycle t → `drop_req` = 1 in cycle t+1.
- `drop_req` stays high through the cycle in which `drop_done` = 1, and is 0 in the following cycle.
- `drop_done` may arrive no earlier than one cycle after `drop_req` rises; there is no upper bound.
- `drop_done` in cycle d:
  - valid drop → SETTLE occupies cycles d+1 … d+SETTLE_CYCLES; the new `turn` or `game_over` appears in cycle d+SETTLE_CYCLES+1.
  - invalid drop → `invalid_move` = 1 in cycle d+1, and state is SELECT in cycle d+1.
- Cursor moves are visible on `col_sel` one cycle after the pulse.
- `drop_done` or `drop_invalid` seen outside DROP is ignored.
- Reset asserted mid-DROP or mid-SETTLE: `drop_req` = 0 and all outputs hold reset values from the next edge. The scheduler does not clear the board; the datapath shares `rst`.

## Configuration
- **MOVE_TIMEOUT_EN defined:**
  - A clog2(TIMEOUT_CYCLES)-bit counter runs only in SELECT.
  - It clears on every accepted owner pulse (move or put) and on each entry to SELECT.
  - On reaching TIMEOUT_CYCLES-1: `timeout` pulses and an automatic put is issued in the current `col_sel` column.
  - If that automatic drop returns `drop_invalid`: `invalid_move` pulses and `turn` toggles (turn forfeited).
- **MOVE_TIMEOUT_EN undefined:** no counter is built, `timeout` is tied to 0, and SELECT waits indefinitely.

## Test plan
- Reset, then local_player=0, loc_right ×3, then loc_put → `col_sel`=0b0001000; in cycle t+1, `drop_req`=1 with `drop_col`=0b0001000 and `drop_player`=0.
- Remote pulses during the local turn are ignored. `col_sel`=1, loc_left → `col_sel`=0b1000000 (wrap-around). loc_left and loc_right in the same cycle → no change.
- Drop acknowledged with `drop_done` and `drop_invalid`=1 → `invalid_move`=1 in cycle d+1, `turn` unchanged (0), state back in SELECT.
- Valid drop with `win_a`=1 during SETTLE (SETTLE_CYCLES=2) → `game_over`=1 in cycle d+3. Later put pulses are ignored. `new_game` → `board_clear` pulse, `turn`=0, `col_sel`=1.
- Reset asserted while `drop_req`=1 and `drop_done` is withheld → next cycle `drop_req`=0 and all outputs at reset values.
- With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=16, idle in SELECT → `timeout` pulse in the 16th cycle after SELECT entry, `drop_req` with `drop_col`=`col_sel` one cycle later. Without MOVE_TIMEOUT_EN → `timeout` stays 0 and no drop is issued.

Source files
------------

// File: rtl/move_scheduler.sv
// Connect-4 turn controller: arbitrates local/remote requesters, sequences drops and settles win/full checks.
// Optional per-turn idle timeout with automatic drop is built when MOVE_TIMEOUT_EN is defined.
module move_scheduler #(
    parameter int COLS           = 7,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_loc_left,
    input  logic            i_loc_right,
    input  logic            i_loc_put,
    input  logic            i_rem_left,
    input  logic            i_rem_right,
    input  logic            i_rem_put,
    input  logic            i_local_player,
    input  logic            i_new_game,
    output logic            o_drop_req,
    output logic [COLS-1:0] o_drop_col,
    output logic            o_drop_player,
    input  logic            i_drop_done,
    input  logic            i_drop_invalid,
    input  logic            i_win_a,
    input  logic            i_win_b,
    input  logic            i_full_panel,
    output logic [COLS-1:0] o_col_sel,
    output logic            o_turn,
    output logic            o_local_turn,
    output logic            o_invalid_move,
    output logic            o_board_clear,
    output logic            o_game_over,
    output logic            o_timeout
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [COLS-1:0] COL_HOME = {{(COLS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_SELECT = 2'd0,
        S_DROP   = 2'd1,
        S_SETTLE = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [COLS-1:0] r_col_sel, w_col_sel_nxt;
    logic [COLS-1:0] r_drop_col, w_drop_col_nxt;
    logic            r_turn, w_turn_nxt;
    logic            r_drop_player, w_drop_player_nxt;
    logic            r_invalid_move, w_invalid_move_nxt;
    logic            r_board_clear, w_board_clear_nxt;
    logic            r_drop_req, r_game_over;
    logic [SW-1:0]   r_settle_cnt, w_settle_cnt_nxt;

    logic w_local_turn, w_own_left, w_own_right, w_own_put, w_put, w_auto_drop;

    // Only the player owning the turn may steer the cursor or drop.
    assign w_local_turn = (r_turn == i_local_player);
    assign w_own_left   = w_local_turn ? i_loc_left  : i_rem_left;
    assign w_own_right  = w_local_turn ? i_loc_right : i_rem_right;
    assign w_own_put    = w_local_turn ? i_loc_put   : i_rem_put;

`ifdef MOVE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
    logic          r_timeout, w_tmo_nxt;
    logic          r_auto;

    // The registered timeout pulse doubles as the automatic put one cycle later.
    assign w_put       = w_own_put | r_timeout;
    assign w_auto_drop = r_auto;
    assign o_timeout   = r_timeout;

    // Idle counter: runs only while SELECT sees no owner activity.
    always_comb begin
        w_tmo_cnt_nxt = '0;
        w_tmo_nxt     = 1'b0;
        if (r_state == S_SELECT && !w_put && !w_own_left && !w_own_right) begin
            if (r_tmo_cnt == TMO_LAST) begin
                w_tmo_nxt = 1'b1;
            end else begin
                w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
            end
        end else begin
            w_tmo_cnt_nxt = '0;
        end
    end

    // Timeout state; r_auto remembers whether the pending drop was forced.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
            r_auto    <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_timeout <= w_tmo_nxt;
            r_auto    <= (r_state == S_SELECT) ? r_timeout : r_auto;
        end
    end
`else
    assign w_put       = w_own_put;
    assign w_auto_drop = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    // Next-state and next-output logic for the turn sequencer.
    always_comb begin
        w_state_nxt        = r_state;
        w_col_sel_nxt      = r_col_sel;
        w_turn_nxt         = r_turn;
        w_drop_col_nxt     = r_drop_col;
        w_drop_player_nxt  = r_drop_player;
        w_invalid_move_nxt = 1'b0;
        w_board_clear_nxt  = 1'b0;
        w_settle_cnt_nxt   = r_settle_cnt;
        case (r_state)
            S_SELECT: begin
                if (w_put) begin
                    w_drop_col_nxt    = r_col_sel;
                    w_drop_player_nxt = r_turn;
                    w_state_nxt       = S_DROP;
                end else if (w_own_left && !w_own_right) begin
                    w_col_sel_nxt = {r_col_sel[0], r_col_sel[COLS-1:1]};
                end else if (w_own_right && !w_own_left) begin
                    w_col_sel_nxt = {r_col_sel[COLS-2:0], r_col_sel[COLS-1]};
                end else begin
                    w_col_sel_nxt = r_col_sel;
                end
            end
            S_DROP: begin
                w_settle_cnt_nxt = '0;
                if (i_drop_done) begin
                    if (i_drop_invalid) begin
                        w_invalid_move_nxt = 1'b1;
                        w_state_nxt        = S_SELECT;
                        w_turn_nxt         = w_auto_drop ? ~r_turn : r_turn;
                    end else begin
                        w_state_nxt = S_SETTLE;
                    end
                end else begin
                    w_state_nxt = S_DROP;
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_settle_cnt_nxt = '0;
                    if (i_win_a || i_win_b || i_full_panel) begin
                        w_state_nxt = S_OVER;
                    end else begin
                        w_turn_nxt  = ~r_turn;
                        w_state_nxt = S_SELECT;
                    end
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + SW'(1);
                end
            end
            S_OVER: begin
                if (i_new_game) begin
                    w_board_clear_nxt = 1'b1;
                    w_turn_nxt        = 1'b0;
                    w_col_sel_nxt     = COL_HOME;
                    w_state_nxt       = S_SELECT;
                end else begin
                    w_state_nxt = S_OVER;
                end
            end
            default: begin
                w_state_nxt = S_SELECT;
            end
        endcase
    end

    // State and registered outputs; drop_req/game_over decode the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_SELECT;
            r_col_sel      <= COL_HOME;
            r_turn         <= 1'b0;
            r_drop_col     <= '0;
            r_drop_player  <= 1'b0;
            r_invalid_move <= 1'b0;
            r_board_clear  <= 1'b0;
            r_settle_cnt   <= '0;
            r_drop_req     <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_col_sel      <= w_col_sel_nxt;
            r_turn         <= w_turn_nxt;
            r_drop_col     <= w_drop_col_nxt;
            r_drop_player  <= w_drop_player_nxt;
            r_invalid_move <= w_invalid_move_nxt;
            r_board_clear  <= w_board_clear_nxt;
            r_settle_cnt   <= w_settle_cnt_nxt;
            r_drop_req     <= (w_state_nxt == S_DROP);
            r_game_over    <= (w_state_nxt == S_OVER);
        end
    end

    assign o_drop_req     = r_drop_req;
    assign o_drop_col     = r_drop_col;
    assign o_drop_player  = r_drop_player;
    assign o_col_sel      = r_col_sel;
    assign o_turn         = r_turn;
    assign o_local_turn   = w_local_turn;
    assign o_invalid_move = r_invalid_move;
    assign o_board_clear  = r_board_clear;
    assign o_game_over    = r_game_over;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: vector table for the main game flow plus reset/timeout sequences.
module tb_move_scheduler;

    logic clk = 1'b0;
    logic rst;
    logic loc_left, loc_right, loc_put, rem_left, rem_right, rem_put;
    logic local_player, new_game, drop_done, drop_invalid, win_a, win_b, full_panel;
    logic drop_req, drop_player, turn, local_turn, invalid_move, board_clear, game_over, timeout;
    logic [6:0] drop_col, col_sel;

    int n_checks = 0;
    int n_fail   = 0;

    move_scheduler #(.COLS(7), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_loc_left(loc_left), .i_loc_right(loc_right), .i_loc_put(loc_put),
        .i_rem_left(rem_left), .i_rem_right(rem_right), .i_rem_put(rem_put),
        .i_local_player(local_player), .i_new_game(new_game),
        .o_drop_req(drop_req), .o_drop_col(drop_col), .o_drop_player(drop_player),
        .i_drop_done(drop_done), .i_drop_invalid(drop_invalid),
        .i_win_a(win_a), .i_win_b(win_b), .i_full_panel(full_panel),
        .o_col_sel(col_sel), .o_turn(turn), .o_local_turn(local_turn),
        .o_invalid_move(invalid_move), .o_board_clear(board_clear),
        .o_game_over(game_over), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    // input bit order: {loc_left, loc_right, loc_put, rem_left, rem_right, rem_put, drop_done, drop_invalid, win_a, new_game}
    localparam logic [9:0] LL = 10'b1000000000, LR = 10'b0100000000, LP = 10'b0010000000;
    localparam logic [9:0] RL = 10'b0001000000, RR = 10'b0000100000, RP = 10'b0000010000;
    localparam logic [9:0] DD = 10'b0000001000, DI = 10'b0000000100, WA = 10'b0000000010;
    localparam logic [9:0] NG = 10'b0000000001, NO = 10'b0000000000;

    typedef struct {
        logic [9:0] in;
        logic [6:0] col;
        logic       turn;
        logic       req;
        logic [6:0] dcol;
        logic       dply;
        logic       inv;
        logic       over;
        logic       clr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [9:0] in, input logic [6:0] col, input logic t, input logic req,
                       input logic [6:0] dcol, input logic dply, input logic inv, input logic over,
                       input logic clr);
        vec_t v;
        v.in = in; v.col = col; v.turn = t; v.req = req; v.dcol = dcol; v.dply = dply;
        v.inv = inv; v.over = over; v.clr = clr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [9:0] in);
        {loc_left, loc_right, loc_put, rem_left, rem_right, rem_put,
         drop_done, drop_invalid, win_a, new_game} = in;
    endtask

    task automatic step(input logic [9:0] in);
        apply(in);
        @(posedge clk);
        #1;
    endtask

    // {col_sel, turn, drop_req, invalid_move, game_over, board_clear, timeout, local_turn}
    function automatic logic [31:0] outs();
        return {18'd0, col_sel, turn, drop_req, invalid_move, game_over, board_clear, timeout, local_turn};
    endfunction

    function automatic logic [31:0] exp_outs(input logic [6:0] col, input logic t, input logic req,
                                             input logic inv, input logic over, input logic clr,
                                             input logic lt);
        return {18'd0, col, t, req, inv, over, clr, 1'b0, lt};
    endfunction

    int  first_k;
    logic seen_tmo, seen_req;

    initial begin
        rst = 1'b1; local_player = 1'b0; win_b = 1'b0; full_panel = 1'b0;
        apply(NO);
        step(NO);
        check("reset", outs(), exp_outs(7'b0000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        check("reset_drop", {drop_col, drop_player}, 32'd0);
        rst = 1'b0;

        add(RR,      7'b0000001, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0); // remote ignored
        add(LL,      7'b1000000, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0); // wrap left
        add(LR,      7'b0000001, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0); // wrap right
        add(LL | LR, 7'b0000001, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0); // both: no move
        add(LR,      7'b0000010, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(LR,      7'b0000100, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(LR,      7'b0001000, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(LP,      7'b0001000, 1'b0, 1'b1, 7'b0001000, 1'b0, 1'b0, 1'b0, 1'b0); // drop_req at t+1
        add(LR,      7'b0001000, 1'b0, 1'b1, 7'b0001000, 1'b0, 1'b0, 1'b0, 1'b0); // moves ignored in DROP
        add(DD | DI, 7'b0001000, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b1, 1'b0, 1'b0); // invalid, keep turn
        add(DD | DI, 7'b0001000, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0); // ack outside DROP
        add(LP,      7'b0001000, 1'b0, 1'b1, 7'b0001000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(DD,      7'b0001000, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0); // settle d+1
        add(NO,      7'b0001000, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0); // settle d+2
        add(NO,      7'b0001000, 1'b1, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0); // turn passes d+3
        add(LR | NG, 7'b0001000, 1'b1, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0); // non-owner, new_game ignored
        add(RL,      7'b0000100, 1'b1, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(RP,      7'b0000100, 1'b1, 1'b1, 7'b0000100, 1'b1, 1'b0, 1'b0, 1'b0);
        add(DD | WA, 7'b0000100, 1'b1, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(WA,      7'b0000100, 1'b1, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(WA,      7'b0000100, 1'b1, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0); // game_over d+3
        add(RP | LP | RR, 7'b0000100, 1'b1, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0); // frozen
        add(NG,      7'b0000001, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b1); // restart
        add(NO,      7'b0000001, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].in);
            check($sformatf("vec%0d", i), outs(),
                  exp_outs(vecs[i].col, vecs[i].turn, vecs[i].req, vecs[i].inv,
                           vecs[i].over, vecs[i].clr, ~vecs[i].turn));
            if (vecs[i].req) begin
                check($sformatf("vec%0d_drop", i), {drop_col, drop_player}, {vecs[i].dcol, vecs[i].dply});
            end
        end

        // Reset in the middle of a pending drop, with the local side as player B.
        local_player = 1'b1; rst = 1'b1;
        step(NO);
        rst = 1'b0;
        check("reset_lp1", outs(), exp_outs(7'b0000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(RR);
        check("remote_move", outs(), exp_outs(7'b0000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(RP);
        step(NO);
        check("drop_held", {drop_req, drop_col, drop_player}, {1'b1, 7'b0000010, 1'b0});
        rst = 1'b1;
        step(NO);
        rst = 1'b0;
        check("reset_mid_drop", outs(), exp_outs(7'b0000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        check("reset_mid_drop_col", {drop_col, drop_player}, 32'd0);

        // Idle in SELECT, counting cycles from the first cycle after reset.
        first_k = 0; seen_tmo = 1'b0; seen_req = 1'b0;
        for (int k = 1; k <= 40 && first_k == 0; k++) begin
            step(NO);
            if (timeout) begin
                first_k = k;
                seen_tmo = 1'b1;
            end
            if (drop_req) seen_req = 1'b1;
        end
`ifdef MOVE_TIMEOUT_EN
        check("timeout_cycle", first_k, 32'd16);
        check("timeout_no_early_req", {31'd0, seen_req}, 32'd0);
        step(NO);
        check("auto_drop", {timeout, drop_req, drop_col}, {1'b0, 1'b1, 7'b0000001});
        step(DD | DI);
        check("auto_forfeit", {invalid_move, turn, drop_req}, {1'b1, 1'b1, 1'b0});
`else
        check("no_timeout", {30'd0, seen_tmo, seen_req}, 32'd0);
        check("still_select", outs(), exp_outs(7'b0000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
